// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage operand block of the 16-bit, 4-register CPU.
// It holds the register file and selects each source operand from the register
// file or from one of three in-flight results. It drives the compare flags used
// by the ID branch logic and loads the ID/EX pipeline register.
// Build option: define ID_WRITE_BYPASS_EN to make a same-cycle register-file
// write visible on the read ports (write-through). Without it, a read returns
// the stored value and the new value appears after the clock edge.
//
// Pipeline qualification: valid_ID_EX_out marks a real instruction in ID/EX.
// There is no ready signal. hold is the stall and keeps every ID/EX output.
// flush inserts a bubble and overrides hold. When neither is asserted, the
// register loads on every rising edge.
module id_operand_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rs,
    input  logic [1:0]            rt,
    input  logic [1:0]            rd_in,
    input  logic                  RegWrite_in,
    input  logic                  instr_valid_in,
    input  logic [1:0]            IDforwardA,
    input  logic [1:0]            IDforwardB,
    input  logic [DATA_WIDTH-1:0] fwd_mem_wb_data,
    input  logic [DATA_WIDTH-1:0] fwd_ex_mem_data,
    input  logic [DATA_WIDTH-1:0] fwd_id_ex_data,
    input  logic                  wb_write,
    input  logic [1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  hold,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic                  cmp_eq,
    output logic                  cmp_a_neg,
    output logic                  cmp_a_zero,
    output logic [DATA_WIDTH-1:0] rs_data_ID_EX_out,
    output logic [DATA_WIDTH-1:0] rt_data_ID_EX_out,
    output logic [1:0]            rd_ID_EX_out,
    output logic                  RegWrite_ID_EX_out,
    output logic                  valid_ID_EX_out
);

    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
    logic [DATA_WIDTH-1:0] rsRead;
    logic [DATA_WIDTH-1:0] rtRead;

    // Forwarding code: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 ID/EX.
    function automatic logic [DATA_WIDTH-1:0] selOperand(
        input logic [1:0]            code,
        input logic [DATA_WIDTH-1:0] regVal
    );
        logic [DATA_WIDTH-1:0] result;
        case (code)
            2'b01:   result = fwd_mem_wb_data;
            2'b10:   result = fwd_ex_mem_data;
            2'b11:   result = fwd_id_ex_data;
            default: result = regVal;
        endcase
        return result;
    endfunction

    // Register-file write port. Hold and flush do not block it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (wb_write) begin
            regFile[wb_addr] <= wb_data;
        end
    end

    // Asynchronous read ports, with optional write-through of the pending write.
    always_comb begin
        rsRead = regFile[rs];
        rtRead = regFile[rt];
`ifdef ID_WRITE_BYPASS_EN
        if (wb_write && (wb_addr == rs)) rsRead = wb_data;
        if (wb_write && (wb_addr == rt)) rtRead = wb_data;
`endif
    end

    // Operand selection and branch-compare flags, all combinational.
    always_comb begin
        operand_a  = selOperand(IDforwardA, rsRead);
        operand_b  = selOperand(IDforwardB, rtRead);
        cmp_eq     = (operand_a == operand_b);
        cmp_a_neg  = operand_a[DATA_WIDTH-1];
        cmp_a_zero = (operand_a == '0);
    end

    // ID/EX pipeline register. Priority is flush, then hold, then load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_data_ID_EX_out  <= '0;
            rt_data_ID_EX_out  <= '0;
            rd_ID_EX_out       <= '0;
            RegWrite_ID_EX_out <= 1'b0;
            valid_ID_EX_out    <= 1'b0;
        end else if (flush) begin
            rs_data_ID_EX_out  <= '0;
            rt_data_ID_EX_out  <= '0;
            rd_ID_EX_out       <= '0;
            RegWrite_ID_EX_out <= 1'b0;
            valid_ID_EX_out    <= 1'b0;
        end else if (!hold) begin
            rs_data_ID_EX_out  <= operand_a;
            rt_data_ID_EX_out  <= operand_b;
            rd_ID_EX_out       <= rd_in;
            RegWrite_ID_EX_out <= RegWrite_in & instr_valid_in;
            valid_ID_EX_out    <= instr_valid_in;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed and randomized checks of id_operand_stage
// against a behavioural model of the register file, operand selection and
// ID/EX register. Honors ID_WRITE_BYPASS_EN the same way as the design.
module tb_id_operand_stage;

`ifdef ID_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- DUT signals ----------------
    logic [1:0]  rs, rt, rd_in, IDforwardA, IDforwardB, wb_addr;
    logic        RegWrite_in, instr_valid_in, wb_write, hold, flush;
    logic [15:0] fwd_mem_wb_data, fwd_ex_mem_data, fwd_id_ex_data, wb_data;
    logic [15:0] operand_a, operand_b, rs_data_ID_EX_out, rt_data_ID_EX_out;
    logic        cmp_eq, cmp_a_neg, cmp_a_zero;
    logic [1:0]  rd_ID_EX_out;
    logic        RegWrite_ID_EX_out, valid_ID_EX_out;

    id_operand_stage dut (
        .clk(clk), .reset_n(reset_n),
        .rs(rs), .rt(rt), .rd_in(rd_in),
        .RegWrite_in(RegWrite_in), .instr_valid_in(instr_valid_in),
        .IDforwardA(IDforwardA), .IDforwardB(IDforwardB),
        .fwd_mem_wb_data(fwd_mem_wb_data), .fwd_ex_mem_data(fwd_ex_mem_data),
        .fwd_id_ex_data(fwd_id_ex_data),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .hold(hold), .flush(flush),
        .operand_a(operand_a), .operand_b(operand_b),
        .cmp_eq(cmp_eq), .cmp_a_neg(cmp_a_neg), .cmp_a_zero(cmp_a_zero),
        .rs_data_ID_EX_out(rs_data_ID_EX_out), .rt_data_ID_EX_out(rt_data_ID_EX_out),
        .rd_ID_EX_out(rd_ID_EX_out), .RegWrite_ID_EX_out(RegWrite_ID_EX_out),
        .valid_ID_EX_out(valid_ID_EX_out)
    );

    // ---------------- reference model ----------------
    logic [15:0] m_reg [4];
    // Expected ID/EX word: {valid, regwrite, rd[1:0], a[15:0], b[15:0]}
    logic [35:0] m_idex;
    logic [35:0] exp_q[$];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // The register-file value that a read at addr sees in the current cycle.
    function automatic logic [15:0] model_read(input logic [1:0] addr);
        if (BYPASS && wb_write && wb_addr == addr) return wb_data;
        return m_reg[addr];
    endfunction

    // Operand sources listed in forwarding-code order.
    function automatic logic [15:0] model_operand(input logic [1:0] code, input logic [1:0] addr);
        logic [15:0] src [4];
        src[0] = model_read(addr);
        src[1] = fwd_mem_wb_data;
        src[2] = fwd_ex_mem_data;
        src[3] = fwd_id_ex_data;
        return src[code];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
        m_idex = '0;
    endtask

    task automatic check_idex(input string tag);
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 16'h1, 16'h0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, {15'b0, valid_ID_EX_out}, {15'b0, e[35]});
        check({tag, "_regwrite"}, {15'b0, RegWrite_ID_EX_out}, {15'b0, e[34]});
        check({tag, "_rd"}, {14'b0, rd_ID_EX_out}, {14'b0, e[33:32]});
        check({tag, "_rs_data"}, rs_data_ID_EX_out, e[31:16]);
        check({tag, "_rt_data"}, rt_data_ID_EX_out, e[15:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rs = 0; rt = 0; rd_in = 0; RegWrite_in = 0; instr_valid_in = 0;
        IDforwardA = 0; IDforwardB = 0; wb_write = 0; wb_addr = 0; wb_data = 0;
        fwd_mem_wb_data = 0; fwd_ex_mem_data = 0; fwd_id_ex_data = 0;
        hold = 0; flush = 0;
    endtask

    // Called just after a negedge with inputs driven. It checks the
    // combinational outputs, clocks one edge, and then checks ID/EX.
    task automatic cycle(input string tag);
        logic [15:0] a, b;
        #1;
        a = model_operand(IDforwardA, rs);
        b = model_operand(IDforwardB, rt);
        check({tag, "_operand_a"}, operand_a, a);
        check({tag, "_operand_b"}, operand_b, b);
        check({tag, "_cmp_eq"}, {15'b0, cmp_eq}, {15'b0, a == b});
        check({tag, "_cmp_a_neg"}, {15'b0, cmp_a_neg}, {15'b0, a >= 16'h8000});
        check({tag, "_cmp_a_zero"}, {15'b0, cmp_a_zero}, {15'b0, a == 16'h0});
        @(posedge clk);
        if (flush) m_idex = '0;
        else if (!hold) m_idex = {instr_valid_in, RegWrite_in & instr_valid_in, rd_in, a, b};
        if (wb_write) m_reg[wb_addr] = wb_data;
        exp_q.push_back(m_idex);
        #1;
        check_idex(tag);
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [15:0] data);
        idle_inputs();
        wb_write = 1; wb_addr = addr; wb_data = data;
        cycle("wr");
        wb_write = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] pre_bypass;
        idle_inputs();
        model_reset();
        reset_n = 0;
        #1;
        check("rst_valid", {15'b0, valid_ID_EX_out}, 16'h0);
        check("rst_rs_data", rs_data_ID_EX_out, 16'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;

        // Preload R2 and load a valid instruction. Then reset in mid-cycle.
        write_reg(2'd2, 16'h1234);
        rs = 2; rt = 2; rd_in = 1; RegWrite_in = 1; instr_valid_in = 1;
        cycle("preload");
        check("preload_known", rs_data_ID_EX_out, 16'h1234);
        #2 reset_n = 0;
        #1;
        model_reset();
        check("async_rst_valid", {15'b0, valid_ID_EX_out}, 16'h0);
        check("async_rst_regwrite", {15'b0, RegWrite_ID_EX_out}, 16'h0);
        check("async_rst_rd", {14'b0, rd_ID_EX_out}, 16'h0);
        check("async_rst_rs_data", rs_data_ID_EX_out, 16'h0);
        check("async_rst_rt_data", rt_data_ID_EX_out, 16'h0);
        @(negedge clk);
        reset_n = 1;
        idle_inputs();
        rs = 2;
        #1;
        check("post_rst_r2", operand_a, 16'h0000);
        cycle("post_rst");

        // Forward-select sweep for A and B.
        write_reg(2'd1, 16'h0001);
        fwd_mem_wb_data = 16'h1111; fwd_ex_mem_data = 16'h2222; fwd_id_ex_data = 16'h3333;
        rs = 1; rt = 1;
        for (int c = 0; c < 4; c++) begin
            logic [15:0] want [4];
            want[0] = 16'h0001; want[1] = 16'h1111; want[2] = 16'h2222; want[3] = 16'h3333;
            IDforwardA = c[1:0]; IDforwardB = 2'(3 - c);
            #1;
            check("fwd_sweep_a", operand_a, want[c]);
            check("fwd_sweep_b", operand_b, want[3-c]);
            cycle("fwd_sweep");
        end

        // Load, then hold with new inputs, then hold together with flush.
        idle_inputs();
        fwd_mem_wb_data = 16'h00AA; IDforwardA = 2'b01;
        rd_in = 3; RegWrite_in = 1; instr_valid_in = 1;
        cycle("load");
        check("load_rs_data", rs_data_ID_EX_out, 16'h00AA);
        hold = 1; fwd_mem_wb_data = 16'h5A5A; rd_in = 2; RegWrite_in = 0;
        cycle("hold");
        check("hold_rs_data", rs_data_ID_EX_out, 16'h00AA);
        check("hold_rd", {14'b0, rd_ID_EX_out}, 16'h3);
        check("hold_regwrite", {15'b0, RegWrite_ID_EX_out}, 16'h1);
        flush = 1;
        cycle("hold_flush");
        check("flush_valid", {15'b0, valid_ID_EX_out}, 16'h0);
        check("flush_rs_data", rs_data_ID_EX_out, 16'h0);

        // Write and read of the same address in one cycle.
        write_reg(2'd0, 16'h5555);
        idle_inputs();
        wb_write = 1; wb_addr = 0; wb_data = 16'hBEEF; rs = 0;
        pre_bypass = BYPASS ? 16'hBEEF : 16'h5555;
        #1;
        check("wr_rd_same_cycle", operand_a, pre_bypass);
        cycle("wr_rd");
        wb_write = 0;
        #1;
        check("wr_rd_next_cycle", operand_a, 16'hBEEF);
        cycle("wr_rd_next");

        // Compare flags.
        idle_inputs();
        IDforwardA = 2'b01; IDforwardB = 2'b10;
        fwd_mem_wb_data = 16'h8000; fwd_ex_mem_data = 16'h8000;
        #1;
        check("cmp_eq_8000", {15'b0, cmp_eq}, 16'h1);
        check("cmp_neg_8000", {15'b0, cmp_a_neg}, 16'h1);
        check("cmp_zero_8000", {15'b0, cmp_a_zero}, 16'h0);
        cycle("cmp_8000");
        fwd_mem_wb_data = 16'h0000;
        #1;
        check("cmp_zero_0", {15'b0, cmp_a_zero}, 16'h1);
        cycle("cmp_0");

        // Invalid instruction must not write.
        idle_inputs();
        RegWrite_in = 1; instr_valid_in = 0; rd_in = 2;
        cycle("invalid");
        check("invalid_valid", {15'b0, valid_ID_EX_out}, 16'h0);
        check("invalid_regwrite", {15'b0, RegWrite_ID_EX_out}, 16'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rs = 2'($urandom_range(0, 3)); rt = 2'($urandom_range(0, 3));
            rd_in = 2'($urandom_range(0, 3));
            RegWrite_in = 1'($urandom_range(0, 1));
            instr_valid_in = ($urandom_range(0, 3) != 0);
            IDforwardA = 2'($urandom_range(0, 3)); IDforwardB = 2'($urandom_range(0, 3));
            fwd_mem_wb_data = 16'($urandom); fwd_ex_mem_data = 16'($urandom);
            fwd_id_ex_data = ($urandom_range(0, 7) == 0) ? fwd_mem_wb_data : 16'($urandom);
            wb_write = 1'($urandom_range(0, 1)); wb_addr = 2'($urandom_range(0, 3));
            wb_data = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            hold = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
